// File: rtl/tpu_pkg.sv
// Shared constants and state encoding for the TPU SRAM loader.
package tpu_pkg;

  localparam int SRAM_DATA_WIDTH = 32;
  localparam int ADDR_WIDTH      = 10;
  localparam int NUM_BANKS       = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_D = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_FIN    = 3'd5
  } state_t;

endpackage

// File: rtl/tpu_sram_loader_if.sv
// Host word stream into the loader: valid/ready handshake with one data word.
interface tpu_sram_loader_if #(
  parameter int DATA_WIDTH = tpu_pkg::SRAM_DATA_WIDTH
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/loader_addr_gen.sv
// Bank-sequential write address generator: address within bank, bank within
// group, and weight/data group, advanced once per accepted host word.
module loader_addr_gen #(
  parameter int ADDR_WIDTH = tpu_pkg::ADDR_WIDTH,
  parameter int NUM_BANKS  = tpu_pkg::NUM_BANKS,
  parameter int BANK_W     = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [BANK_W-1:0]     bank,
  output logic                  group,
  output logic                  last_word
);
  import tpu_pkg::*;

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [BANK_W-1:0]     bank_reg;
  logic                  group_reg;
  logic [ADDR_WIDTH:0]   len_m1;
  logic                  addr_last;
  logic                  bank_last;

  // Full-width compare: with len=0 the wrapped len_m1 never matches.
  assign len_m1    = len - 1'b1;
  assign addr_last = ({1'b0, addr_reg} == len_m1);
  assign bank_last = (bank_reg == BANK_W'(NUM_BANKS - 1));

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      addr_reg  <= '0;
      bank_reg  <= '0;
      group_reg <= 1'b0;
    end else if (clear) begin
      addr_reg  <= '0;
      bank_reg  <= '0;
      group_reg <= 1'b0;
    end else if (advance) begin
      if (addr_last) begin
        addr_reg <= '0;
        if (bank_last) begin
          bank_reg  <= '0;
          group_reg <= ~group_reg;
        end else begin
          bank_reg <= bank_reg + 1'b1;
        end
      end else begin
        addr_reg <= addr_reg + 1'b1;
      end
    end
  end

  assign addr      = addr_reg;
  assign bank      = bank_reg;
  assign group     = group_reg;
  assign last_word = addr_last && bank_last;

endmodule

// File: rtl/tpu_sram_loader.sv
// Streams host words into the weight then data SRAM banks, kicks the TPU and
// reports job completion with a one-cycle done pulse.
module tpu_sram_loader #(
  parameter int SRAM_DATA_WIDTH = tpu_pkg::SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH      = tpu_pkg::ADDR_WIDTH,
  parameter int NUM_BANKS       = tpu_pkg::NUM_BANKS
) (
  input  logic                       clk,
  input  logic                       srstn,
  input  logic                       load_start,
  input  logic [ADDR_WIDTH:0]        load_words,
  tpu_sram_loader_if.slave           host,
  output logic [NUM_BANKS-1:0]       sram_wen_w,
  output logic [NUM_BANKS-1:0]       sram_wen_d,
  output logic [ADDR_WIDTH-1:0]      sram_waddr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wdata,
  output logic                       tpu_start,
  input  logic                       tpu_done,
  output logic                       busy,
  output logic                       done
);
  import tpu_pkg::*;

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                     state_reg;
  logic [ADDR_WIDTH:0]        len_reg;
  logic                       in_ready_reg;
  logic                       busy_reg;
  logic                       tpu_start_reg;
  logic                       done_reg;
  logic [NUM_BANKS-1:0]       wen_w_reg;
  logic [NUM_BANKS-1:0]       wen_d_reg;
  logic [ADDR_WIDTH-1:0]      waddr_reg;
  logic [SRAM_DATA_WIDTH-1:0] wdata_reg;

  logic [ADDR_WIDTH:0]   len_clamped;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [BANK_W-1:0]     cur_bank;
  logic                  cur_group;
  logic                  last_word;
  logic [NUM_BANKS-1:0]  bank_sel;

  assign len_clamped = (load_words > MAX_LEN) ? MAX_LEN : load_words;
  assign accept      = host.in_valid && in_ready_reg;

  loader_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_BANKS  (NUM_BANKS),
    .BANK_W     (BANK_W)
  ) u_addr_gen (
    .clk       (clk),
    .srstn     (srstn),
    .clear     (state_reg == S_IDLE),
    .advance   (accept),
    .len       (len_reg),
    .addr      (cur_addr),
    .bank      (cur_bank),
    .group     (cur_group),
    .last_word (last_word)
  );

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_sel
    assign bank_sel[gi] = (cur_bank == BANK_W'(gi));
  end

  // in_ready and busy are loaded with the decode of the next state so both
  // track the state register exactly without a combinational path.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_reg     <= S_IDLE;
      len_reg       <= '0;
      in_ready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      tpu_start_reg <= 1'b0;
      done_reg      <= 1'b0;
      wen_w_reg     <= '0;
      wen_d_reg     <= '0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
    end else begin
      wen_w_reg     <= '0;
      wen_d_reg     <= '0;
      tpu_start_reg <= 1'b0;
      done_reg      <= 1'b0;

      if (accept) begin
        waddr_reg <= cur_addr;
        wdata_reg <= host.in_data;
        if (cur_group) wen_d_reg <= bank_sel;
        else           wen_w_reg <= bank_sel;
      end

      case (state_reg)
        S_IDLE: begin
          if (load_start) begin
            len_reg  <= len_clamped;
            busy_reg <= 1'b1;
            if (len_clamped != '0) begin
              state_reg    <= S_LOAD_W;
              in_ready_reg <= 1'b1;
            end else begin
              state_reg <= S_START;
            end
          end
        end
        S_LOAD_W: begin
          if (accept && last_word) state_reg <= S_LOAD_D;
        end
        S_LOAD_D: begin
          if (accept && last_word) begin
            state_reg    <= S_START;
            in_ready_reg <= 1'b0;
          end
        end
        S_START: begin
          tpu_start_reg <= 1'b1;
          state_reg     <= S_WAIT;
        end
        S_WAIT: begin
          if (tpu_done) begin
            done_reg  <= 1'b1;
            state_reg <= S_FIN;
          end
        end
        S_FIN: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg    <= S_IDLE;
          in_ready_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign host.in_ready = in_ready_reg;
  assign sram_wen_w    = wen_w_reg;
  assign sram_wen_d    = wen_d_reg;
  assign sram_waddr    = waddr_reg;
  assign sram_wdata    = wdata_reg;
  assign tpu_start     = tpu_start_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_tpu_sram_loader.sv
// Directed + randomized bench for tpu_sram_loader against a word-index model
// of the bank-sequential fill order.
module tb_tpu_sram_loader;
  import tpu_pkg::*;

  localparam int N  = NUM_BANKS;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = SRAM_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          srstn = 1'b0;
  logic          load_start = 1'b0;
  logic [AW:0]   load_words = '0;
  logic          tpu_done = 1'b0;
  wire  [N-1:0]  sram_wen_w;
  wire  [N-1:0]  sram_wen_d;
  wire  [AW-1:0] sram_waddr;
  wire  [DW-1:0] sram_wdata;
  wire           tpu_start;
  wire           busy;
  wire           done;

  tpu_sram_loader_if #(.DATA_WIDTH(DW)) host ();

  tpu_sram_loader dut (
    .clk        (clk),
    .srstn      (srstn),
    .load_start (load_start),
    .load_words (load_words),
    .host       (host),
    .sram_wen_w (sram_wen_w),
    .sram_wen_d (sram_wen_d),
    .sram_waddr (sram_waddr),
    .sram_wdata (sram_wdata),
    .tpu_start  (tpu_start),
    .tpu_done   (tpu_done),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        grp;
    logic [7:0]  bank;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  wr_t     wr_q[$];
  int      start_q[$];
  int      done_q[$];
  int      tdone_cyc = 0;
  int      ls_cyc = 0;
  int      ready_cnt = 0;
  int      bad_wen = 0;
  int      hold_err = 0;
  int      last_wbase = 0;
  logic [AW-1:0] prev_waddr = '0;
  logic [DW-1:0] prev_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every write and pulse with the cycle it was visible in.
  always @(negedge clk) begin
    wr_t w;
    if (srstn) begin
      if ((|sram_wen_w) || (|sram_wen_d)) begin
        if ($countones({sram_wen_w, sram_wen_d}) != 1) bad_wen++;
        w.cyc  = cyc;
        w.grp  = |sram_wen_d;
        w.bank = 8'd0;
        for (int i = N - 1; i >= 0; i--)
          if (sram_wen_w[i] || sram_wen_d[i]) w.bank = 8'(i);
        w.addr = 16'(sram_waddr);
        w.data = 32'(sram_wdata);
        wr_q.push_back(w);
      end else if (sram_waddr !== prev_waddr || sram_wdata !== prev_wdata) begin
        hold_err++;
      end
      if (tpu_start)     start_q.push_back(cyc);
      if (done)          done_q.push_back(cyc);
      if (tpu_done)      tdone_cyc = cyc;
      if (load_start)    ls_cyc = cyc;
      if (host.in_ready) ready_cnt++;
    end
    prev_waddr = sram_waddr;
    prev_wdata = sram_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic next_valid(input int mode, input int p);
    if (mode == 1) return (p % 4 == 0) || (p % 4 == 3);
    if (mode == 2) return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] next_data(input int mode, input int idx);
    if (mode == 0) return DW'(idx);
    return DW'($urandom);
  endfunction

  task automatic check_write(input string tag, input int k, input int g, input int b,
                             input int a, input logic [31:0] d);
    wr_t w;
    w = wr_q[last_wbase + k];
    check(tag, {w.grp, w.bank, w.addr, w.data}, {1'(g), 8'(b), 16'(a), d});
  endtask

  // One job: mode 0 = valid always high with word index as data,
  // mode 1 = valid pattern 1,0,0,1, mode 2 = random valid and data.
  task automatic run_job(input int lw, input int mode, input bit poke, input int abort_at,
                         input string tag);
    int L, total, wbase, sbase, dbase, rbase, hbase, bbase, sent, guard, p, nw, r;
    bit acc, poked, poke_active;
    logic [DW-1:0] words[$];
    wr_t w;
    int eg, eb, ea;
    L      = (lw > (1 << AW)) ? (1 << AW) : lw;
    total  = 2 * N * L;
    wbase  = wr_q.size();
    sbase  = start_q.size();
    dbase  = done_q.size();
    rbase  = ready_cnt;
    hbase  = hold_err;
    bbase  = bad_wen;
    last_wbase = wbase;
    sent = 0; guard = 0; p = 0; poked = 0; poke_active = 0;

    @(posedge clk); #1;
    load_start = 1'b1;
    load_words = (AW + 1)'(lw);
    @(posedge clk); #1;
    load_start = 1'b0;
    host.in_valid = (total > 0) ? next_valid(mode, p) : 1'b0;
    host.in_data  = next_data(mode, sent);

    while (sent < total && guard < total * 8 + 100) begin
      @(negedge clk);
      acc = host.in_valid && host.in_ready;
      if (acc) begin
        words.push_back(host.in_data);
        sent++;
      end
      @(posedge clk); #1;
      guard++;
      p++;
      if (abort_at > 0 && sent == abort_at) begin
        #1 srstn = 1'b0;
        #1;
        check({tag, "_rst_outputs"},
              {sram_wen_w, sram_wen_d, sram_waddr, sram_wdata, tpu_start, done, host.in_ready},
              '0);
        check({tag, "_rst_busy"}, busy, 1'b0);
        host.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 srstn = 1'b1;
        repeat (6) @(negedge clk);
        check({tag, "_rst_no_start"}, start_q.size() - sbase, 0);
        check({tag, "_rst_idle"}, {busy, host.in_ready}, 2'b00);
        return;
      end
      if (poke_active) begin
        load_start  = 1'b0;
        tpu_done    = 1'b0;
        poke_active = 0;
      end
      if (poke && !poked && sent >= 5) begin
        load_start  = 1'b1;
        load_words  = (AW + 1)'(1);
        tpu_done    = 1'b1;
        poked       = 1;
        poke_active = 1;
      end
      if (acc || !host.in_valid) begin
        host.in_valid = next_valid(mode, p);
        host.in_data  = next_data(mode, sent);
      end
      if (sent >= total) host.in_valid = 1'b0;
    end
    host.in_valid = 1'b0;
    load_start    = 1'b0;
    tpu_done      = 1'b0;
    check({tag, "_words_accepted"}, sent, total);

    for (int i = 0; i < 20 && start_q.size() == sbase; i++) @(negedge clk);
    check({tag, "_start_count"}, start_q.size() - sbase, 1);

    r = $urandom_range(0, 3);
    repeat (r) @(posedge clk);
    @(posedge clk); #1;
    tpu_done = 1'b1;
    @(posedge clk); #1;
    tpu_done = 1'b0;
    for (int i = 0; i < 10 && done_q.size() == dbase; i++) @(negedge clk);
    @(negedge clk);

    nw = wr_q.size() - wbase;
    check({tag, "_write_count"}, nw, total);
    for (int k = 0; k < nw && k < total; k++) begin
      w  = wr_q[wbase + k];
      eg = k / (N * L);
      eb = (k / L) % N;
      ea = k % L;
      check($sformatf("%s_write_%0d", tag, k), {w.grp, w.bank, w.addr, w.data},
            {1'(eg), 8'(eb), 16'(ea), 32'(words[k])});
    end
    if (start_q.size() > sbase) begin
      if (total > 0 && nw > 0)
        check({tag, "_start_after_last_wen"}, start_q[sbase], wr_q[wr_q.size() - 1].cyc + 1);
      else if (total == 0)
        check({tag, "_start_latency"}, start_q[sbase], ls_cyc + 2);
    end
    if (total == 0) check({tag, "_ready_never"}, ready_cnt - rbase, 0);
    check({tag, "_done_count"}, done_q.size() - dbase, 1);
    if (done_q.size() > dbase)
      check({tag, "_done_latency"}, done_q[dbase], tdone_cyc + 1);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_wen_onehot"}, bad_wen - bbase, 0);
    check({tag, "_wbus_hold"}, hold_err - hbase, 0);
    $display("job %s L=%0d words=%0d writes=%0d", tag, L, sent, nw);
  endtask

  initial begin
    host.in_valid = 1'b0;
    host.in_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {sram_wen_w, sram_wen_d, sram_waddr, sram_wdata, tpu_start, busy, done, host.in_ready},
          '0);
    #1 srstn = 1'b1;
    repeat (2) @(negedge clk);

    run_job(4, 0, 0, 0, "basic");
    for (int a = 0; a < 4; a++) check_write($sformatf("basic_w0_a%0d", a), a, 0, 0, a, 32'(a));
    check_write("basic_w7_a3", 31, 0, 7, 3, 32'h1F);
    check_write("basic_d0_a0", 32, 1, 0, 0, 32'h20);
    check_write("basic_d7_a3", 63, 1, 7, 3, 32'h3F);

    run_job(2, 1, 0, 0, "gaps");
    run_job(0, 0, 0, 0, "zero_len");
    run_job(3, 2, 1, 0, "ignored");
    run_job($urandom_range(1, 5), 2, 0, 0, "random");
    run_job(2, 0, 0, 10, "midreset");
    run_job(1, 2, 0, 0, "after_reset");
    check_write("after_reset_w0_a0_bank", 0, 0, 0, 0, wr_q[last_wbase].data);

    run_job(1025, 0, 0, 0, "clamp");
    check_write("clamp_last_weight", N * 1024 - 1, 0, 7, 1023, 32'(N * 1024 - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
